// File: rtl/flag_bank_stack_if.sv
// Bundle of the flag bank's operation inputs and status outputs.
// The master drives the operations; the slave is the flag bank itself.
interface flag_bank_stack_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [1:0]       i_op;
  logic [WIDTH-1:0] i_mask;
  logic [WIDTH-1:0] i_d_in;
  logic             i_push;
  logic             i_pop;
  logic             i_err_clr;
  logic [WIDTH-1:0] o_flags;
  logic [CW-1:0]    o_count;
  logic             o_full;
  logic             o_empty;
  logic             o_ovf_err;
  logic             o_unf_err;

  modport master (
    output i_op, i_mask, i_d_in, i_push, i_pop, i_err_clr,
    input  o_flags, o_count, o_full, o_empty, o_ovf_err, o_unf_err
  );

  modport slave (
    input  i_op, i_mask, i_d_in, i_push, i_pop, i_err_clr,
    output o_flags, o_count, o_full, o_empty, o_ovf_err, o_unf_err
  );
endinterface

// File: rtl/flag_bank_stack.sv
// WIDTH-bit status flag register with masked load/set/clear and a DEPTH-entry
// LIFO shadow stack for save/restore; all state changes on the falling edge.
module flag_bank_stack #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  flag_bank_stack_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] r_flags;
  logic [CW-1:0]    r_count;
  logic             r_ovf_err;
  logic             r_unf_err;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [WIDTH-1:0] w_op_val;
  logic             w_full;
  logic             w_empty;
  logic             w_push_only;
  logic             w_pop_only;
  logic             w_do_push;
  logic             w_do_pop;
  logic             w_ovf;
  logic             w_unf;
  logic [CW-1:0]    w_cnt_inc;
  logic [CW-1:0]    w_cnt_dec;
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_rd_idx;
  logic [WIDTH-1:0] w_flags_next;
  logic [CW-1:0]    w_count_next;

  // Per-bit op decode; unmasked bits and unknown op codes hold.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      always_comb begin
        w_op_val[gi] = r_flags[gi];
        if (bus.i_mask[gi]) begin
          case (bus.i_op)
            2'b01:   w_op_val[gi] = bus.i_d_in[gi];
            2'b10:   w_op_val[gi] = 1'b1;
            2'b11:   w_op_val[gi] = 1'b0;
            default: w_op_val[gi] = r_flags[gi];
          endcase
        end
      end
    end
  endgenerate

  assign w_full      = (r_count == DEPTH_C);
  assign w_empty     = (r_count == '0);
  // Simultaneous push and pop cancel out so control glitches are harmless.
  assign w_push_only = bus.i_push & ~bus.i_pop;
  assign w_pop_only  = bus.i_pop & ~bus.i_push;
  assign w_do_push   = w_push_only & ~w_full;
  assign w_do_pop    = w_pop_only & ~w_empty;
  assign w_ovf       = w_push_only & w_full;
  assign w_unf       = w_pop_only & w_empty;

  assign w_cnt_inc = r_count + ONE;
  assign w_cnt_dec = r_count - ONE;
  assign w_wr_idx  = r_count[AW-1:0];
  assign w_rd_idx  = w_cnt_dec[AW-1:0];

  // A restore overrides the op; otherwise the op always applies.
  always_comb begin
    w_flags_next = w_op_val;
    if (w_do_pop) begin
      w_flags_next = r_mem[w_rd_idx];
    end
  end

  always_comb begin
    w_count_next = r_count;
    if (w_do_push) begin
      w_count_next = w_cnt_inc;
    end else if (w_do_pop) begin
      w_count_next = w_cnt_dec;
    end
  end

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      r_flags   <= '0;
      r_count   <= '0;
      r_ovf_err <= 1'b0;
      r_unf_err <= 1'b0;
    end else begin
      r_flags   <= w_flags_next;
      r_count   <= w_count_next;
      r_ovf_err <= w_ovf | (r_ovf_err & ~bus.i_err_clr);
      r_unf_err <= w_unf | (r_unf_err & ~bus.i_err_clr);
    end
  end

  // Stack storage has no reset; occupancy alone defines which entries are valid.
  always_ff @(negedge clk) begin
    if (rst_n && w_do_push) begin
      r_mem[w_wr_idx] <= r_flags;
    end
  end

  assign bus.o_flags   = r_flags;
  assign bus.o_count   = r_count;
  assign bus.o_full    = w_full;
  assign bus.o_empty   = w_empty;
  assign bus.o_ovf_err = r_ovf_err;
  assign bus.o_unf_err = r_unf_err;

endmodule
